seg_display_arbiter: RTL and testbench

Shares the board's 8-digit, active-low, time-multiplexed seven-segment display between two independent requesters, for example a countdown timer and a status/ID message source. A round-robin arbiter with a minimum hold time owns the display. A scan engine drives the granted requester's 8 hex nibbles and decimal points onto `led_en` and the segment lines. The block sits between the application counters and the display pins, and replaces per-application scan logic.

---
 rtl/seg_pkg.sv | 61 ++++++
 rtl/seg_display_arbiter_scan.sv | 70 +++++++
 rtl/seg_display_arbiter.sv | 153 +++++++++++++++
 tb/tb_seg_display_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display arbiter: default timing
// constants, arbiter state encoding and the active-low hex segment table.
package seg_pkg;

    // Clock cycles each digit slot is lit (200k cycles at 100 MHz = 2 ms).
    localparam logic [19:0] SCAN_CNT_MAX_DEF = 20'd200_000;
    // Minimum number of cycles a requester keeps the display once granted.
    localparam logic [28:0] HOLD_CNT_MAX_DEF = 29'd100_000_000;

    // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}, dp dark.
    localparam logic [7:0] SEG_0     = 8'hc0;
    localparam logic [7:0] SEG_1     = 8'hf9;
    localparam logic [7:0] SEG_2     = 8'ha4;
    localparam logic [7:0] SEG_3     = 8'hb0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hf8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hc6;
    localparam logic [7:0] SEG_D     = 8'ha1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8e;
    localparam logic [7:0] SEG_BLANK = 8'hff;

    // Arbiter states: nobody owns the display, or requester 0 / 1 owns it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_t;

    // Hex nibble to active-low segment byte; dp is left dark (bit 7 = 1).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'ha:    seg = SEG_A;
            4'hb:    seg = SEG_B;
            4'hc:    seg = SEG_C;
            4'hd:    seg = SEG_D;
            4'he:    seg = SEG_E;
            4'hf:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_scan.sv
// Scan engine: walks the 8 digit slots while enabled, decodes the selected
// nibble and drives registered active-low digit enables and segment lines.
// Disabling the engine parks it at digit 0 and blanks the display.
module seg_scan
    import seg_pkg::*;
#(
    parameter logic [19:0] SCAN_CNT_MAX = SCAN_CNT_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    output logic [7:0]  led_en,
    output logic        led_ca,
    output logic        led_cb,
    output logic        led_cc,
    output logic        led_cd,
    output logic        led_ce,
    output logic        led_cf,
    output logic        led_cg,
    output logic        led_dp
);

    logic [19:0] scan_cnt;
    logic [2:0]  scan_pos;
    logic [3:0]  nibble;
    logic [7:0]  seg_byte;
    logic [7:0]  seg_reg;

    // Pick the current digit's nibble and decode it, dp taken from its own bit.
    always_comb begin
        nibble      = data[{scan_pos, 2'b00} +: 4];
        seg_byte    = hex_to_seg(nibble);
        seg_byte[7] = ~dp[scan_pos];
    end

    // Slot timer and digit position; both clear whenever the scan is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= 20'd0;
            scan_pos <= 3'd0;
        end else if (!enable) begin
            scan_cnt <= 20'd0;
            scan_pos <= 3'd0;
        end else if (scan_cnt == SCAN_CNT_MAX - 20'd1) begin
            scan_cnt <= 20'd0;
            scan_pos <= scan_pos + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 20'd1;
        end
    end

    // Registered display outputs: one digit lit while enabled, dark otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en  <= 8'hff;
            seg_reg <= SEG_BLANK;
        end else if (enable) begin
            led_en  <= ~(8'd1 << scan_pos);
            seg_reg <= seg_byte;
        end else begin
            led_en  <= 8'hff;
            seg_reg <= SEG_BLANK;
        end
    end

    assign {led_dp, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = seg_reg;

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-requester display arbiter: round-robin ownership with a minimum hold
// time, feeding the owner's digits and decimal points into the scan engine.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter logic [19:0] SCAN_CNT_MAX = SCAN_CNT_MAX_DEF,
    parameter logic [28:0] HOLD_CNT_MAX = HOLD_CNT_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [7:0]  dp0,
    input  logic [7:0]  dp1,
    output logic [1:0]  grant,
    output logic [7:0]  led_en,
    output logic        led_ca,
    output logic        led_cb,
    output logic        led_cc,
    output logic        led_cd,
    output logic        led_ce,
    output logic        led_cf,
    output logic        led_cg,
    output logic        led_dp
);

    arb_state_t  state;
    logic        last;
    logic [28:0] hold_cnt;
    logic        hold_done;
    logic        scan_enable;
    logic [31:0] sel_data;
    logic [7:0]  sel_dp;

    // Once the hold counter parks at its last value the owner may be replaced.
    assign hold_done   = (hold_cnt == HOLD_CNT_MAX - 29'd1);
    assign scan_enable = (state != IDLE);

    // Arbiter FSM with hold counter; last records the most recent owner to leave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 2'b00;
            last     <= 1'b1;
            hold_cnt <= 29'd0;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= 29'd0;
                    if (req0 && req1) begin
                        if (last) begin
                            state <= G0;
                            grant <= 2'b01;
                        end else begin
                            state <= G1;
                            grant <= 2'b10;
                        end
                    end else if (req0) begin
                        state <= G0;
                        grant <= 2'b01;
                    end else if (req1) begin
                        state <= G1;
                        grant <= 2'b10;
                    end else begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                G0: begin
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt + 29'd1;
                    end else if (req1) begin
                        state    <= G1;
                        grant    <= 2'b10;
                        last     <= 1'b0;
                        hold_cnt <= 29'd0;
                    end else if (!req0) begin
                        state    <= IDLE;
                        grant    <= 2'b00;
                        last     <= 1'b0;
                        hold_cnt <= 29'd0;
                    end else begin
                        state <= G0;
                        grant <= 2'b01;
                    end
                end
                G1: begin
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt + 29'd1;
                    end else if (req0) begin
                        state    <= G0;
                        grant    <= 2'b01;
                        last     <= 1'b1;
                        hold_cnt <= 29'd0;
                    end else if (!req1) begin
                        state    <= IDLE;
                        grant    <= 2'b00;
                        last     <= 1'b1;
                        hold_cnt <= 29'd0;
                    end else begin
                        state <= G1;
                        grant <= 2'b10;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= 2'b00;
                    hold_cnt <= 29'd0;
                end
            endcase
        end
    end

    // Route the current owner's digits and decimal points to the scan engine.
    always_comb begin
        case (state)
            G0: begin
                sel_data = data0;
                sel_dp   = dp0;
            end
            G1: begin
                sel_data = data1;
                sel_dp   = dp1;
            end
            default: begin
                sel_data = 32'd0;
                sel_dp   = 8'd0;
            end
        endcase
    end

    seg_scan #(
        .SCAN_CNT_MAX(SCAN_CNT_MAX)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .enable (scan_enable),
        .data   (sel_data),
        .dp     (sel_dp),
        .led_en (led_en),
        .led_ca (led_ca),
        .led_cb (led_cb),
        .led_cc (led_cc),
        .led_cd (led_cd),
        .led_ce (led_ce),
        .led_cf (led_cf),
        .led_cg (led_cg),
        .led_dp (led_dp)
    );

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter (SCAN=5, HOLD=15). Stimulus pushes
// cycle-stamped expectations; a negedge monitor pops and compares them.
module tb_seg_display_arbiter;

    localparam logic [19:0] SCAN = 20'd5;
    localparam logic [28:0] HOLD = 29'd15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] data0, data1;
    logic [7:0]  dp0, dp1;
    logic [1:0]  grant;
    logic [7:0]  led_en;
    logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;

    typedef struct {
        int         cyc;
        int         id;
        bit         cg;
        logic [1:0] g;
        bit         ce;
        logic [7:0] e;
        bit         cs;
        logic [7:0] s;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ts;

    logic [7:0] en_tab  [8];
    logic [7:0] seg_a   [8];
    logic [7:0] seg_hex [8];

    seg_display_arbiter #(
        .SCAN_CNT_MAX(SCAN),
        .HOLD_CNT_MAX(HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .data0  (data0),
        .data1  (data1),
        .dp0    (dp0),
        .dp1    (dp1),
        .grant  (grant),
        .led_en (led_en),
        .led_ca (led_ca),
        .led_cb (led_cb),
        .led_cc (led_cc),
        .led_cd (led_cd),
        .led_ce (led_ce),
        .led_cf (led_cf),
        .led_cg (led_cg),
        .led_dp (led_dp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        logic [7:0] seg_now;
        seg_now = {led_dp, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            if (x.cyc < cyc) begin
                n_checks++;
                $display("FAIL missed #%0d: due cycle %0d, seen at cycle %0d", x.id, x.cyc, cyc);
            end else begin
                if (x.cg) begin
                    n_checks++;
                    if (grant === x.g) n_pass++;
                    else $display("FAIL grant #%0d cycle %0d: got %b want %b", x.id, cyc, grant, x.g);
                end
                if (x.ce) begin
                    n_checks++;
                    if (led_en === x.e) n_pass++;
                    else $display("FAIL led_en #%0d cycle %0d: got %h want %h", x.id, cyc, led_en, x.e);
                end
                if (x.cs) begin
                    n_checks++;
                    if (seg_now === x.s) n_pass++;
                    else $display("FAIL segs #%0d cycle %0d: got %h want %h", x.id, cyc, seg_now, x.s);
                end
            end
        end
    end

    task automatic push(input int c, input int id, input bit cg, input logic [1:0] g,
                        input bit ce, input logic [7:0] e, input bit cs, input logic [7:0] s);
        exp_t x;
        int   i;
        x.cyc = c; x.id = id; x.cg = cg; x.g = g; x.ce = ce; x.e = e; x.cs = cs; x.s = s;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, x);
    endtask

    task automatic exp_g(input int c, input int id, input logic [1:0] g);
        push(c, id, 1'b1, g, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic exp_en(input int c, input int id, input logic [7:0] e);
        push(c, id, 1'b0, 2'b00, 1'b1, e, 1'b0, 8'h00);
    endtask

    task automatic exp_d(input int c, input int id, input logic [7:0] e, input logic [7:0] s);
        push(c, id, 1'b0, 2'b00, 1'b1, e, 1'b1, s);
    endtask

    task automatic exp_rst(input int c, input int id);
        push(c, id, 1'b1, 2'b00, 1'b1, 8'hff, 1'b1, 8'hff);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        en_tab  = '{8'hfe, 8'hfd, 8'hfb, 8'hf7, 8'hef, 8'hdf, 8'hbf, 8'h7f};
        seg_a   = '{8'hc0, 8'hc0, 8'h80, 8'ha4, 8'h99, 8'hc0, 8'hc0, 8'ha4};
        // FEDC_BA98 with dp0=81: digits 0 and 7 carry a lit dp (bit 7 cleared)
        seg_hex = '{8'h00, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h0e};

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        data0 = 32'd0; data1 = 32'd0; dp0 = 8'd0; dp1 = 8'd0;

        // Reset state, during and after release
        tick(3);
        exp_rst(cyc, 1);
        rst = 1'b0;
        exp_rst(cyc + 1, 2);
        exp_rst(cyc + 2, 3);
        tick(3);

        // Single requester: grant latency, digit walk, release latency
        ts = cyc;
        req0 = 1'b1; data0 = 32'h2004_2800; dp0 = 8'h00;
        exp_g(ts, 10, 2'b00);
        exp_g(ts + 1, 11, 2'b01);
        exp_en(ts + 1, 12, 8'hff);
        for (int k = 0; k < 8; k++) begin
            exp_d(ts + 2 + 5 * k, 100 + k, en_tab[k], seg_a[k]);
            exp_d(ts + 6 + 5 * k, 110 + k, en_tab[k], seg_a[k]);
        end
        tick(45);
        req0 = 1'b0;
        exp_g(ts + 45, 13, 2'b01);
        exp_g(ts + 46, 14, 2'b00);
        exp_en(ts + 46, 15, 8'hfe);
        exp_d(ts + 47, 16, 8'hff, 8'hff);
        tick(5);

        // Asynchronous reset mid-frame in G0
        ts = cyc;
        req0 = 1'b1; data0 = 32'h1111_1111;
        tick(19);
        exp_g(cyc, 20, 2'b01);
        exp_en(cyc, 21, 8'hf7);
        tick(1);
        rst = 1'b1; req0 = 1'b0;
        exp_rst(cyc, 22);
        tick(1);
        exp_rst(cyc, 23);
        rst = 1'b0;
        tick(2);

        // Simultaneous requests: G0 first for exactly HOLD cycles, then G1
        ts = cyc;
        req0 = 1'b1; req1 = 1'b1;
        exp_g(ts, 30, 2'b00);
        exp_g(ts + 1, 31, 2'b01);
        exp_g(ts + 15, 32, 2'b01);
        exp_g(ts + 16, 33, 2'b10);
        tick(20);
        req0 = 1'b0; req1 = 1'b0;
        exp_g(ts + 30, 34, 2'b10);
        exp_g(ts + 31, 35, 2'b00);
        tick(13);
        req0 = 1'b1; req1 = 1'b1;
        exp_g(ts + 34, 36, 2'b01);
        tick(2);
        do_reset();

        // Early drop: grant held until saturation, then dark one cycle later
        ts = cyc;
        req1 = 1'b1; data1 = 32'd0; dp1 = 8'd0;
        exp_g(ts + 1, 40, 2'b10);
        tick(4);
        req1 = 1'b0;
        exp_g(ts + 10, 41, 2'b10);
        exp_g(ts + 15, 42, 2'b10);
        exp_g(ts + 16, 43, 2'b00);
        exp_en(ts + 16, 44, 8'hfb);
        exp_d(ts + 17, 45, 8'hff, 8'hff);
        tick(20);
        do_reset();

        // Hex decode over all digits and decimal points
        ts = cyc;
        req0 = 1'b1; data0 = 32'hFEDC_BA98; dp0 = 8'h81;
        for (int k = 0; k < 8; k++) exp_d(ts + 2 + 5 * k, 200 + k, en_tab[k], seg_hex[k]);
        tick(45);
        req0 = 1'b0;
        tick(20);
        do_reset();

        // Switch G0 -> G1 at scan_pos 3: scan continues with data1
        ts = cyc;
        req0 = 1'b1; req1 = 1'b1;
        data0 = 32'd0; data1 = 32'h7654_3210; dp0 = 8'd0; dp1 = 8'd0;
        exp_g(ts + 15, 50, 2'b01);
        exp_g(ts + 16, 51, 2'b10);
        exp_d(ts + 16, 52, 8'hfb, 8'hc0);
        exp_d(ts + 17, 53, 8'hf7, 8'hb0);
        exp_d(ts + 21, 54, 8'hf7, 8'hb0);
        exp_d(ts + 22, 55, 8'hef, 8'h99);
        tick(23);
        req0 = 1'b0; req1 = 1'b0;
        tick(3);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 300 && sb.size() > 0; i++) tick(1);
        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            n_checks++;
            $display("FAIL timeout #%0d: due cycle %0d never checked", x.id, x.cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
